// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Holds the FSM state encoding, default widths and the index-width helper.
package uart_tx_scheduler_pkg;

   localparam int unsigned DEF_BYTE_W = 8;
   localparam int unsigned DEF_WORD_W = 4 * DEF_BYTE_W;
   localparam int unsigned CNT_W      = 2;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_SEND      = 3'd2,
      S_WAIT_BSY  = 3'd3,
      S_WAIT_DONE = 3'd4
   } state_e;

   // Index width that stays legal for a single requester.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and UART-side signals of the transmit scheduler.
// master = scheduler, slave = requesters plus uart core.
interface uart_tx_scheduler_if
   import uart_tx_scheduler_pkg::*;
#(
   parameter int unsigned N_REQ  = 2,
   parameter int unsigned WORD_W = DEF_WORD_W,
   parameter int unsigned BYTE_W = DEF_BYTE_W
);
   localparam int unsigned IDX_W = idx_w(N_REQ);

   logic [N_REQ-1:0]        req;
   logic [N_REQ*WORD_W-1:0] req_data;
   logic [N_REQ*CNT_W-1:0]  req_len;
   logic [N_REQ-1:0]        ack;
   logic                    tx_ena;
   logic [BYTE_W-1:0]       tx_data;
   logic                    tx_busy;
   logic [IDX_W-1:0]        owner;
   logic                    active;
   logic                    tmo_err;

   modport master (
      input  req, req_data, req_len, tx_busy,
      output ack, tx_ena, tx_data, owner, active, tmo_err
   );

   modport slave (
      output req, req_data, req_len, tx_busy,
      input  ack, tx_ena, tx_data, owner, active, tmo_err
   );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
// Returns a one-hot grant, its index and a valid flag.
module uart_tx_scheduler_rr_arbiter #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);

   always_comb begin
      grant = '0;
      idx   = '0;
      vld   = 1'b0;
      // Offset k from ptr maps to requester i when ptr+k == i or ptr+k == i+N_REQ.
      for (int k = 0; k < int'(N_REQ); k++) begin
         for (int i = 0; i < int'(N_REQ); i++) begin
            if (!vld && req[i] &&
                ((int'(ptr) + k == i) || (int'(ptr) + k == i + int'(N_REQ)))) begin
               vld      = 1'b1;
               grant[i] = 1'b1;
               idx      = IDX_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one byte-wide UART transmitter between N_REQ word-wide requesters.
// Round-robin picks a word, then sends 1-4 bytes MSB-first over tx_ena/tx_busy.
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int unsigned N_REQ   = 2,
   parameter int unsigned WORD_W  = DEF_WORD_W,
   parameter int unsigned BYTE_W  = DEF_BYTE_W,
   parameter int unsigned BSY_TMO = 16
) (
   input  logic                clk,
   input  logic                reset,
   uart_tx_scheduler_if.master bus
);

   localparam int unsigned IDX_W = idx_w(N_REQ);
   localparam int unsigned TMO_W = $clog2(BSY_TMO + 1);

   state_e              state_q,   state_d;
   logic [WORD_W-1:0]   shift_q,   shift_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic [TMO_W-1:0]    tmo_q,     tmo_d;
   logic [IDX_W-1:0]    rr_ptr_q,  rr_ptr_d;
   logic [IDX_W-1:0]    owner_q,   owner_d;
   logic [N_REQ-1:0]    ack_q,     ack_d;
   logic                tx_ena_q,  tx_ena_d;
   logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
   logic                active_q,  active_d;
   logic                tmo_err_q, tmo_err_d;

   logic [N_REQ-1:0]    grant;
   logic [IDX_W-1:0]    grant_idx;
   logic                grant_vld;
   logic [WORD_W-1:0]   word_sel;
   logic [CNT_W-1:0]    len_sel;

   uart_tx_scheduler_rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req   (bus.req),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .idx   (grant_idx),
      .vld   (grant_vld)
   );

   // Word and length of the granted requester.
   always_comb begin
      word_sel = '0;
      len_sel  = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (grant[i]) begin
            word_sel = bus.req_data[i*int'(WORD_W) +: WORD_W];
            len_sel  = bus.req_len[i*int'(CNT_W) +: CNT_W];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      ack_d     = '0;
      tx_ena_d  = 1'b0;
      tx_data_d = tx_data_q;
      active_d  = active_q;
      tmo_err_d = tmo_err_q;

      unique case (state_q)
         // Capture on the decision edge so ack/active are visible during LOAD.
         S_IDLE: begin
            if (grant_vld && !bus.tx_busy) begin
               owner_d  = grant_idx;
               ack_d    = grant;
               shift_d  = word_sel;
               cnt_d    = len_sel;
               active_d = 1'b1;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            tx_ena_d  = 1'b1;
            tx_data_d = shift_q[WORD_W-1 -: BYTE_W];
            state_d   = S_SEND;
         end
         S_SEND: begin
            tmo_d   = '0;
            state_d = S_WAIT_BSY;
         end
         S_WAIT_BSY: begin
            if (bus.tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (tmo_q >= TMO_W'(BSY_TMO - 1)) begin
               tmo_d     = TMO_W'(BSY_TMO);
               tmo_err_d = 1'b1;
               active_d  = 1'b0;
               state_d   = S_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!bus.tx_busy) begin
               if (cnt_q == '0) begin
                  active_d = 1'b0;
                  rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                  state_d  = S_IDLE;
               end else begin
                  shift_d   = shift_q << BYTE_W;
                  cnt_d     = cnt_q - CNT_W'(1);
                  tx_ena_d  = 1'b1;
                  tx_data_d = shift_q[WORD_W-BYTE_W-1 -: BYTE_W];
                  state_d   = S_SEND;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         ack_q     <= '0;
         tx_ena_q  <= 1'b0;
         tx_data_q <= '0;
         active_q  <= 1'b0;
         tmo_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         ack_q     <= ack_d;
         tx_ena_q  <= tx_ena_d;
         tx_data_q <= tx_data_d;
         active_q  <= active_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign bus.ack     = ack_q;
   assign bus.tx_ena  = tx_ena_q;
   assign bus.tx_data = tx_data_q;
   assign bus.owner   = owner_q;
   assign bus.active  = active_q;
   assign bus.tmo_err = tmo_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: table of single words, hand sequences for
// rotation/timeout/reset/busy-block, and random word FIFOs against a queue model.
module tb_uart_tx_scheduler;
   import uart_tx_scheduler_pkg::*;

   localparam int N  = 2;
   localparam int BT = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_tx_scheduler_if #(.N_REQ(N), .WORD_W(32), .BYTE_W(8)) bus ();

   uart_tx_scheduler #(.N_REQ(N), .WORD_W(32), .BYTE_W(8), .BSY_TMO(BT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // UART model: busy rises the cycle after tx_ena and stays for busy_len cycles.
   int   bsy_cnt    = 0;
   int   busy_len   = 3;
   bit   never_busy = 1'b0;
   bit   force_busy = 1'b0;
   int   ena_while_busy = 0;
   logic [7:0] byte_log[$];
   int         own_log[$];

   assign bus.tx_busy = (bsy_cnt != 0) || force_busy;

   always @(posedge clk) begin
      if (bus.tx_ena) begin
         byte_log.push_back(bus.tx_data);
         own_log.push_back(int'(bus.owner));
         if (bus.tx_busy) ena_while_busy++;
      end
      if (bus.tx_ena && !never_busy) bsy_cnt <= busy_len;
      else if (bsy_cnt != 0)         bsy_cnt <= bsy_cnt - 1;
   end

   // Requester FIFOs and the reference model state.
   logic [31:0] wq[N][$];
   logic [1:0]  lq[N][$];
   int          ack_cnt[N];
   int          model_ptr = 0;
   logic [7:0]  exp_b[$];
   int          exp_o[$];

   typedef struct {
      int          rq;
      logic [31:0] word;
      logic [1:0]  len;
      int          blen;
      int          nbytes;
      logic [31:0] exp_bytes;
   } vec_t;
   vec_t tbl[4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive_req();
      for (int i = 0; i < N; i++) begin
         bus.req[i]            = (wq[i].size() != 0);
         bus.req_data[i*32 +: 32] = (wq[i].size() != 0) ? wq[i][0] : 32'h0;
         bus.req_len[i*2 +: 2]    = (lq[i].size() != 0) ? lq[i][0] : 2'h0;
      end
   endtask

   task automatic pop_acks();
      for (int i = 0; i < N; i++) begin
         if (bus.ack[i]) begin
            ack_cnt[i]++;
            if (wq[i].size() != 0) begin
               wq[i].delete(0);
               lq[i].delete(0);
            end
         end
      end
   endtask

   // Serve FIFOs until all words are done and the uart is idle, or budget expires.
   task automatic run(input int budget, input string nm);
      int  cyc;
      bit  done;
      cyc  = 0;
      done = 1'b0;
      drive_req();
      while (!done) begin
         @(negedge clk);
         pop_acks();
         drive_req();
         cyc++;
         if (wq[0].size() == 0 && wq[1].size() == 0 && !bus.active && !bus.tx_busy)
            done = 1'b1;
         else if (cyc >= budget) begin
            total++;
            bad++;
            $display("FAIL %s timeout: actual=busy after %0d cycles required=done", nm, cyc);
            done = 1'b1;
         end
      end
   endtask

   // Rotation model: pick first pending FIFO from model_ptr, emit len+1 bytes MSB first.
   task automatic model_expect();
      logic [31:0] mw[N][$];
      logic [1:0]  ml[N][$];
      logic [31:0] w;
      int          l;
      int          pick;
      for (int i = 0; i < N; i++) begin
         mw[i] = wq[i];
         ml[i] = lq[i];
      end
      exp_b.delete();
      exp_o.delete();
      pick = 0;
      while (pick >= 0) begin
         pick = -1;
         for (int k = 0; k < N; k++) begin
            if (pick < 0 && mw[(model_ptr + k) % N].size() != 0) pick = (model_ptr + k) % N;
         end
         if (pick >= 0) begin
            w = mw[pick].pop_front();
            l = int'(ml[pick].pop_front());
            for (int b = 0; b <= l; b++) begin
               exp_b.push_back(8'(w >> (24 - 8*b)));
               exp_o.push_back(pick);
            end
            model_ptr = (pick + 1) % N;
         end
      end
   endtask

   task automatic compare_log(input string nm);
      chk({nm, " nbytes"}, 32'(byte_log.size()), 32'(exp_b.size()));
      for (int j = 0; j < byte_log.size() && j < exp_b.size(); j++) begin
         chk($sformatf("%s byte%0d", nm, j), 32'(byte_log[j]), 32'(exp_b[j]));
         chk($sformatf("%s owner%0d", nm, j), 32'(own_log[j]), 32'(exp_o[j]));
      end
   endtask

   task automatic clear_logs();
      byte_log.delete();
      own_log.delete();
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, " ack"},     32'(bus.ack),     32'h0);
      chk({nm, " tx_ena"},  32'(bus.tx_ena),  32'h0);
      chk({nm, " tx_data"}, 32'(bus.tx_data), 32'h0);
      chk({nm, " owner"},   32'(bus.owner),   32'h0);
      chk({nm, " active"},  32'(bus.active),  32'h0);
      chk({nm, " tmo_err"}, 32'(bus.tmo_err), 32'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         wq[i].delete();
         lq[i].delete();
      end
      drive_req();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      model_ptr = 0;
      clear_logs();
   endtask

   initial begin
      logic [7:0]  e2[4];
      int          e2o[4];
      logic [31:0] tmp;
      int          acks0;
      int          nwords;
      int          wait_cyc;
      int          seen;

      for (int i = 0; i < N; i++) ack_cnt[i] = 0;
      drive_req();
      do_reset();

      // Single-word table: requester, word, len, busy cycles, expected bytes.
      tbl[0] = '{0, 32'hA1B2C3D4, 2'd3, 10, 4, 32'hA1B2C3D4};
      tbl[1] = '{1, 32'hCAFE0000, 2'd1, 3,  2, 32'hCAFE0000};
      tbl[2] = '{0, 32'h5A123456, 2'd0, 1,  1, 32'h5A000000};
      tbl[3] = '{1, 32'h01020304, 2'd2, 5,  3, 32'h01020300};
      for (int k = 0; k < 4; k++) begin
         clear_logs();
         busy_len = tbl[k].blen;
         acks0    = ack_cnt[tbl[k].rq];
         wq[tbl[k].rq].push_back(tbl[k].word);
         lq[tbl[k].rq].push_back(tbl[k].len);
         model_expect();
         run(400, $sformatf("vec%0d", k));
         chk($sformatf("vec%0d nbytes", k), 32'(byte_log.size()), 32'(tbl[k].nbytes));
         tmp = tbl[k].exp_bytes;
         for (int b = 0; b < tbl[k].nbytes && b < byte_log.size(); b++) begin
            chk($sformatf("vec%0d byte%0d", k, b), 32'(byte_log[b]), 32'(8'(tmp >> (24 - 8*b))));
            chk($sformatf("vec%0d owner%0d", k, b), 32'(own_log[b]), 32'(tbl[k].rq));
         end
         chk($sformatf("vec%0d acks", k), 32'(ack_cnt[tbl[k].rq] - acks0), 32'd1);
         chk($sformatf("vec%0d active", k), 32'(bus.active), 32'h0);
      end

      // Both requesters held, one byte each: strict rotation 0,1,0,1.
      do_reset();
      busy_len = 2;
      wq[0].push_back(32'h11000000); wq[0].push_back(32'h11AABBCC);
      wq[1].push_back(32'h22000000); wq[1].push_back(32'h22DDEEFF);
      for (int i = 0; i < 2; i++) begin
         lq[0].push_back(2'd0);
         lq[1].push_back(2'd0);
      end
      model_expect();
      run(400, "rotate");
      e2  = '{8'h11, 8'h22, 8'h11, 8'h22};
      e2o = '{0, 1, 0, 1};
      chk("rotate nbytes", 32'(byte_log.size()), 32'd4);
      for (int j = 0; j < 4 && j < byte_log.size(); j++) begin
         chk($sformatf("rotate byte%0d", j), 32'(byte_log[j]), 32'(e2[j]));
         chk($sformatf("rotate owner%0d", j), 32'(own_log[j]), 32'(e2o[j]));
      end

      // tx_busy held high blocks arbitration; ack one cycle after release.
      clear_logs();
      force_busy = 1'b1;
      acks0 = ack_cnt[0];
      wq[0].push_back(32'h3C4D5E6F);
      lq[0].push_back(2'd1);
      model_expect();
      drive_req();
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.ack != '0) seen++;
      end
      chk("busyblock acks", 32'(seen), 32'd0);
      chk("busyblock tx_ena", 32'(byte_log.size()), 32'd0);
      force_busy = 1'b0;
      @(negedge clk);
      chk("busyblock ack after release", 32'(bus.ack), 32'h1);
      pop_acks();
      run(400, "busyblock");
      compare_log("busyblock");
      chk("busyblock acks total", 32'(ack_cnt[0] - acks0), 32'd1);

      // uart never answers: sticky timeout, word dropped, later words still served.
      clear_logs();
      never_busy = 1'b1;
      wq[0].push_back(32'hDEADBEEF);
      lq[0].push_back(2'd3);
      drive_req();
      wait_cyc = 0;
      while (byte_log.size() == 0 && wait_cyc < 50) begin
         @(negedge clk);
         pop_acks();
         drive_req();
         wait_cyc++;
      end
      chk("tmo first byte", 32'(byte_log.size() != 0 ? byte_log[0] : 8'h00), 32'hDE);
      repeat (12) @(negedge clk);
      chk("tmo not early", 32'(bus.tmo_err), 32'h0);
      wait_cyc = 0;
      while (!bus.tmo_err && wait_cyc < 20) begin
         @(negedge clk);
         wait_cyc++;
      end
      chk("tmo_err set", 32'(bus.tmo_err), 32'h1);
      @(negedge clk);
      chk("tmo active", 32'(bus.active), 32'h0);
      chk("tmo one tx_ena", 32'(byte_log.size()), 32'd1);
      never_busy = 1'b0;
      busy_len   = 3;
      clear_logs();
      wq[1].push_back(32'h7E7F8081);
      lq[1].push_back(2'd1);
      model_expect();
      run(400, "after_tmo");
      compare_log("after_tmo");
      chk("tmo_err sticky", 32'(bus.tmo_err), 32'h1);

      // Reset while waiting for byte 2 to finish: async abort, restart at byte 0.
      clear_logs();
      busy_len = 10;
      wq[0].push_back(32'h10203040);
      lq[0].push_back(2'd3);
      drive_req();
      wait_cyc = 0;
      while (byte_log.size() < 2 && wait_cyc < 100) begin
         @(negedge clk);
         pop_acks();
         drive_req();
         wait_cyc++;
      end
      chk("midreset bytes before", 32'(byte_log.size()), 32'd2);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      reset = 1'b0;
      model_ptr = 0;
      clear_logs();
      acks0 = ack_cnt[0];
      wq[0].push_back(32'h55667788);
      lq[0].push_back(2'd3);
      model_expect();
      run(400, "after_reset");
      compare_log("after_reset");
      chk("after_reset first byte", 32'(byte_log.size() != 0 ? byte_log[0] : 8'h00), 32'h55);
      chk("after_reset acks", 32'(ack_cnt[0] - acks0), 32'd1);

      // Random FIFO contents checked against the rotation model.
      for (int t = 0; t < 8; t++) begin
         clear_logs();
         busy_len = int'($urandom_range(1, 4));
         nwords   = 0;
         acks0    = ack_cnt[0] + ack_cnt[1];
         for (int i = 0; i < N; i++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
               wq[i].push_back($urandom);
               lq[i].push_back(2'($urandom_range(0, 3)));
               nwords++;
            end
         end
         model_expect();
         run(3000, $sformatf("rand%0d", t));
         compare_log($sformatf("rand%0d", t));
         chk($sformatf("rand%0d acks", t), 32'(ack_cnt[0] + ack_cnt[1] - acks0), 32'(nwords));
      end

      chk("tx_ena while busy", 32'(ena_while_busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
